control_stack_unit: RTL
=======================

// Module: control_stack_unit
// PURPOSE
//  Parametrised next-generation control unit for the accumulator CPU: owns the PC, decodes
//  the opcode into datapath controls and resolves conditional branches from Z/N status.
//  Adds CALL/RET via a return-address stack, a data-memory ready handshake (stall), and HLT.
//  Sits between instruction memory and the ALU/accumulator/data-memory datapath.
// PARAMETERS
//  OPERAND_WIDTH     11  operand field width, PC width and data-memory address width
//  INSTRUCTION_WIDTH 16  instruction width; opcode = instruction_in[IW-1:OW] (OPW = IW-OW bits)
//  STACK_DEPTH        8  return-address stack entries (>=2)
// PORTS
//  clock_in                 in   1      single clock, rising edge
//  reset_in                 in   1      asynchronous, active-high reset
//  instruction_in           in   IW     instruction at instruction_address_out
//  status_Z_in              in   1      zero flag from status register
//  status_N_in              in   1      negative flag from status register
//  mem_ready_in             in   1      data memory ready; 0 stalls memory-access instructions
//  instruction_address_out  out  OW     PC (registered)
//  operand_out              out  OW     instruction_in[OW-1:0], combinational
//  sel_A_out                out  2      acc source: 00 data mem, 01 operand, 10 ALU result
//  sel_B_out                out  1      ALU B: 0 data mem, 1 operand
//  alu_op_out               out  1      0 add, 1 sub
//  data_memory_wr_out       out  1      data-memory write strobe
//  acc_wr_out / status_wr_out out 1     accumulator / status register write enables
//  acc_reset_out / status_reset_out out 1  clear accumulator / status
//  stall_out                out  1      PC held waiting on mem_ready_in
//  halted_out               out  1      HALT state
//  stack_overflow_out / stack_underflow_out out 1  sticky stack error flags
// BEHAVIOUR
//  Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB,
//   00111 SUBI, 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP,
//   01111 CALL, 10000 RET; all others NOP (PC+1, no writes).
//  Reset (async): PC=0, SP=0, flags=0, state=INIT; while reset_in=1 all write enables 0,
//   acc_reset_out=status_reset_out=1.
//  FSM: INIT -> RUN (1 cycle, acc/status reset held 1, PC held); RUN -> HALT on HLT;
//   HALT holds PC, all enables 0, exits only by reset.
//  RUN decode (combinational from instruction_in): STO wr=1; LD sel_A=00, acc_wr; LDI sel_A=01,
//   acc_wr; ADD/SUB sel_B=0, ADDI/SUBI sel_B=1, sel_A=10, acc_wr, status_wr, alu_op per op.
//  Memory instrs (STO, LD, ADD, SUB): mem_ready_in=0 -> stall_out=1, PC held, acc/status_wr=0,
//   data_memory_wr_out stays 1 for STO; complete in the cycle mem_ready_in=1.
//  Branch take: BEQ Z; BNE !Z; BGT !Z&!N; BGE !N; BLT N; BLE N|Z; JMP always -> PC=operand,
//   else PC+1. PC+1 wraps 2^OW-1 -> 0. Decision uses Z/N sampled at the same edge.
//  Latency: PC update one clock after decode; zero wait when mem_ready_in=1.
//  CALL: push PC+1, SP++, PC=operand. RET: SP--, PC=popped value.
//  CALL when SP=STACK_DEPTH: no push, overflow_out=1 (sticky), PC+1. RET when SP=0:
//   underflow_out=1 (sticky), PC+1. Flags clear only on reset.
//  Reset mid-stall or mid-CALL: async clear; no partial stack write survives.
// CONFIGURATION
//  CONTROL_STACK_UNIT_STACK_EN defined: CALL/RET and stack as above.
//  Not defined: no stack storage; CALL/RET decode as NOP; overflow/underflow tied 0.
// TESTING
//  Reset 1 then 0 -> PC=0, acc/status_reset=1 during reset + 1 INIT cycle, then RUN.
//  LDI 5, ADDI 3, STO 2 (ready=1) -> sel_A 01/10, acc_wr each; STO wr=1; PC 0->1->2->3.
//  LD 7 with ready=0 for 3 cycles -> stall_out=1, PC held, acc_wr=0; ready=1 -> acc_wr, PC+1.
//  BGT 0x40 with Z=0,N=0 -> PC=0x40; Z=1 -> PC+1; BLE with N=1 -> taken; PC 0x7FF+1 -> 0.
//  (STACK_EN) CALL 0x100 at PC 4 -> PC=0x100; RET -> PC=5; 9 nested CALLs (depth 8) -> overflow=1.
//  RET with SP=0 -> underflow=1, PC+1; HLT -> halted_out=1, PC frozen until reset.

Source files
------------

// File: rtl/control_stack_unit.sv
// Accumulator-CPU control unit: PC, opcode decode, Z/N branch resolution, memory-ready stall, HLT.
// Define CONTROL_STACK_UNIT_STACK_EN for the CALL/RET return-address stack; without it CALL/RET act as NOP.
module control_stack_unit #(
    parameter int OPERAND_WIDTH     = 11,
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int STACK_DEPTH       = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    input  logic                         status_Z_in,
    input  logic                         status_N_in,
    input  logic                         mem_ready_in,
    output logic [OPERAND_WIDTH-1:0]     instruction_address_out,
    output logic [OPERAND_WIDTH-1:0]     operand_out,
    output logic [1:0]                   sel_A_out,
    output logic                         sel_B_out,
    output logic                         alu_op_out,
    output logic                         data_memory_wr_out,
    output logic                         acc_wr_out,
    output logic                         status_wr_out,
    output logic                         acc_reset_out,
    output logic                         status_reset_out,
    output logic                         stall_out,
    output logic                         halted_out,
    output logic                         stack_overflow_out,
    output logic                         stack_underflow_out
);
    localparam int OW  = OPERAND_WIDTH;
    localparam int OPW = INSTRUCTION_WIDTH - OPERAND_WIDTH;

    localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
    localparam logic [OPW-1:0] OP_STO  = OPW'(1);
    localparam logic [OPW-1:0] OP_LD   = OPW'(2);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(7);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(8);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(9);
    localparam logic [OPW-1:0] OP_BGT  = OPW'(10);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(11);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(12);
    localparam logic [OPW-1:0] OP_BLE  = OPW'(13);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(14);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_t;

    state_t         state, state_nxt;
    logic [OW-1:0]  pc, pc_nxt, pc_inc;
    logic [OPW-1:0] opcode;
    logic           mem_op;
    logic           take;

    assign opcode                  = instruction_in[INSTRUCTION_WIDTH-1:OW];
    assign operand_out             = instruction_in[OW-1:0];
    assign instruction_address_out = pc;
    assign pc_inc                  = pc + OW'(1);
    assign mem_op = (opcode == OP_STO) || (opcode == OP_LD) || (opcode == OP_ADD) || (opcode == OP_SUB);

`ifdef CONTROL_STACK_UNIT_STACK_EN
    localparam logic [OPW-1:0] OP_CALL = OPW'(15);
    localparam logic [OPW-1:0] OP_RET  = OPW'(16);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SPW-1:0] sp;
    logic [AW-1:0]  push_idx, pop_idx;
    logic [OW-1:0]  stack_mem [STACK_DEPTH];
    logic           push, pop, ovf_set, unf_set, ovf_q, unf_q;

    assign push_idx            = sp[AW-1:0];
    assign pop_idx             = AW'(sp - SPW'(1));
    assign stack_overflow_out  = ovf_q;
    assign stack_underflow_out = unf_q;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            sp    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push)
                sp <= sp + SPW'(1);
            else if (pop)
                sp <= sp - SPW'(1);
            if (ovf_set)
                ovf_q <= 1'b1;
            if (unf_set)
                unf_q <= 1'b1;
        end
    end

    // Entries above sp are dead, so storage needs no reset; clearing sp discards any push.
    always_ff @(posedge clock_in) begin
        if (push)
            stack_mem[push_idx] <= pc_inc;
    end
`else
    assign stack_overflow_out  = 1'b0;
    assign stack_underflow_out = 1'b0;
`endif

    always_comb begin
        take = 1'b0;
        case (opcode)
            OP_BEQ:  take = status_Z_in;
            OP_BNE:  take = !status_Z_in;
            OP_BGT:  take = !status_Z_in && !status_N_in;
            OP_BGE:  take = !status_N_in;
            OP_BLT:  take = status_N_in;
            OP_BLE:  take = status_N_in || status_Z_in;
            OP_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_INIT;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        sel_A_out          = 2'b00;
        sel_B_out          = 1'b0;
        alu_op_out         = 1'b0;
        data_memory_wr_out = 1'b0;
        acc_wr_out         = 1'b0;
        status_wr_out      = 1'b0;
        acc_reset_out      = 1'b0;
        status_reset_out   = 1'b0;
        stall_out          = 1'b0;
        halted_out         = 1'b0;
`ifdef CONTROL_STACK_UNIT_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
`endif
        case (state)
            ST_INIT: begin
                acc_reset_out    = 1'b1;
                status_reset_out = 1'b1;
                state_nxt        = ST_RUN;
            end
            ST_HALT: halted_out = 1'b1;
            ST_RUN: begin
                pc_nxt = pc_inc;
                case (opcode)
                    OP_HLT: begin
                        pc_nxt    = pc;
                        state_nxt = ST_HALT;
                    end
                    OP_STO: data_memory_wr_out = 1'b1;
                    OP_LD: begin
                        sel_A_out  = 2'b00;
                        acc_wr_out = 1'b1;
                    end
                    OP_LDI: begin
                        sel_A_out  = 2'b01;
                        acc_wr_out = 1'b1;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        sel_A_out     = 2'b10;
                        sel_B_out     = (opcode == OP_ADDI) || (opcode == OP_SUBI);
                        alu_op_out    = (opcode == OP_SUB) || (opcode == OP_SUBI);
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
                        if (take)
                            pc_nxt = operand_out;
                    end
`ifdef CONTROL_STACK_UNIT_STACK_EN
                    OP_CALL: begin
                        if (sp == SPW'(STACK_DEPTH)) begin
                            ovf_set = 1'b1;
                        end else begin
                            push   = 1'b1;
                            pc_nxt = operand_out;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            unf_set = 1'b1;
                        end else begin
                            pop    = 1'b1;
                            pc_nxt = stack_mem[pop_idx];
                        end
                    end
`endif
                    default: ;
                endcase
                // STO keeps its write strobe up while waiting so memory sees a stable request.
                if (mem_op && !mem_ready_in) begin
                    stall_out     = 1'b1;
                    acc_wr_out    = 1'b0;
                    status_wr_out = 1'b0;
                    pc_nxt        = pc;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end
endmodule
